// File: rtl/dvga_sprite_overlay.sv
// dvga_sprite_overlay: overlays one 2bpp hardware sprite (3-colour palette, index 0 transparent)
// on the RGB stream. All outputs are delayed by two pixel clocks.
`default_nettype none

module dvga_sprite_overlay #(
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int CW       = 8,
  parameter int PW       = 11,
  parameter bit SYNC_POL = 1'b0,
  localparam int AW      = $clog2(SPR_W * SPR_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] r_i,
  input  logic [CW-1:0] g_i,
  input  logic [CW-1:0] b_i,
  input  logic          hsync_i,
  input  logic          vsync_i,
  input  logic          blank_i,
  output logic [CW-1:0] r_o,
  output logic [CW-1:0] g_o,
  output logic [CW-1:0] b_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          blank_o,
  input  logic          cfg_en,
  input  logic [PW-1:0] cfg_x,
  input  logic [PW-1:0] cfg_y,
  input  logic          spr_we,
  input  logic [AW-1:0] spr_addr,
  input  logic [1:0]    spr_wdata,
  input  logic          pal_we,
  input  logic [1:0]    pal_sel,
  input  logic [3*CW-1:0] pal_data
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam logic [PW:0] W_LIM = (PW+1)'(SPR_W);
  localparam logic [PW:0] H_LIM = (PW+1)'(SPR_H);

  logic [PW-1:0] x_cnt, y_cnt;
  logic          blank_q, vs_q;
  logic          act_en;
  logic [PW-1:0] pos_x, pos_y;
  logic          vs_act;

  assign vs_act = (vsync_i == SYNC_POL);

  // Pixel counters and shadowed sprite position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      blank_q <= 1'b1;
      vs_q    <= 1'b0;
      act_en  <= 1'b0;
      pos_x   <= '0;
      pos_y   <= '0;
    end else begin
      blank_q <= blank_i;
      vs_q    <= vs_act;
      x_cnt   <= blank_i ? '0 : x_cnt + 1'b1;
      if (vs_act)
        y_cnt <= '0;
      else if (blank_i && !blank_q)
        y_cnt <= y_cnt + 1'b1;
      if (vs_act && !vs_q) begin
        act_en <= cfg_en;
        pos_x  <= cfg_x;
        pos_y  <= cfg_y;
      end
    end
  end

  // Stage 0: hit test and bitmap address
  logic [PW:0]   dx, dy;
  logic          hit;
  logic [AW-1:0] rd_addr;

  always_comb begin
    dx      = {1'b0, x_cnt} - {1'b0, pos_x};
    dy      = {1'b0, y_cnt} - {1'b0, pos_y};
    hit     = act_en & ~blank_i & (x_cnt >= pos_x) & (dx < W_LIM)
                               & (y_cnt >= pos_y) & (dy < H_LIM);
    rd_addr = {dy[YW-1:0], dx[XW-1:0]};
  end

  logic [1:0] mem [SPR_W*SPR_H];
  logic [1:0] idx_d;

  // Read-before-write: a same-address read returns the old contents
  always_ff @(posedge clk) begin
    if (spr_we)
      mem[spr_addr] <= spr_wdata;
    idx_d <= mem[rd_addr];
  end

  logic            hit_d;
  logic [3*CW-1:0] rgb_d1;
  logic            hs_d1, vs_d1, bl_d1;
  logic [3*CW-1:0] pal1, pal2, pal3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_d  <= 1'b0;
      rgb_d1 <= '0;
      hs_d1  <= ~SYNC_POL;
      vs_d1  <= ~SYNC_POL;
      bl_d1  <= 1'b1;
      pal1   <= '0;
      pal2   <= '0;
      pal3   <= '0;
    end else begin
      hit_d  <= hit;
      rgb_d1 <= {r_i, g_i, b_i};
      hs_d1  <= hsync_i;
      vs_d1  <= vsync_i;
      bl_d1  <= blank_i;
      if (pal_we) begin
        case (pal_sel)
          2'd1:    pal1 <= pal_data;
          2'd2:    pal2 <= pal_data;
          2'd3:    pal3 <= pal_data;
          default: ;
        endcase
      end
    end
  end

  // Stage 1: colour select
  logic [3*CW-1:0] spr_col;
  logic            use_spr;

  always_comb begin
    spr_col = '0;
    case (idx_d)
      2'd1:    spr_col = pal1;
      2'd2:    spr_col = pal2;
      2'd3:    spr_col = pal3;
      default: spr_col = '0;
    endcase
    use_spr = hit_d && (idx_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o     <= '0;
      g_o     <= '0;
      b_o     <= '0;
      hsync_o <= ~SYNC_POL;
      vsync_o <= ~SYNC_POL;
      blank_o <= 1'b1;
    end else begin
      {r_o, g_o, b_o} <= use_spr ? spr_col : rgb_d1;
      hsync_o <= hs_d1;
      vsync_o <= vs_d1;
      blank_o <= bl_d1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dvga_sprite_overlay.sv
// tb_dvga_sprite_overlay: random-stimulus scoreboard bench comparing the overlay against a
// pixel-level reference model driven by the bench's own raster position.
`default_nettype none

module tb_dvga_sprite_overlay;

  localparam int SW = 32;
  localparam int SH = 32;
  localparam int CW = 8;
  localparam int PW = 11;
  localparam int AW = 10;
  localparam bit SP = 1'b0;
  localparam int HB = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] r_i, g_i, b_i, r_o, g_o, b_o;
  logic          hsync_i, vsync_i, blank_i, hsync_o, vsync_o, blank_o;
  logic          cfg_en;
  logic [PW-1:0] cfg_x, cfg_y;
  logic          spr_we, pal_we;
  logic [AW-1:0] spr_addr;
  logic [1:0]    spr_wdata, pal_sel;
  logic [23:0]   pal_data;

  dvga_sprite_overlay #(.SPR_W(SW), .SPR_H(SH), .CW(CW), .PW(PW), .SYNC_POL(SP)) dut (
    .clk(clk), .rst(rst),
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_i(blank_i),
    .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o),
    .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .spr_we(spr_we), .spr_addr(spr_addr), .spr_wdata(spr_wdata),
    .pal_we(pal_we), .pal_sel(pal_sel), .pal_data(pal_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         col;
    int         row;
    logic [26:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int          bm [SW*SH];
  logic [23:0] pal_m [4];
  bit          en_m;
  int          px_m, py_m;
  bit          vs_prev_m;
  bit          ramp;
  int          chg_row;
  int          chg_x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    en_m = 0; px_m = 0; py_m = 0; vs_prev_m = 0;
    for (int i = 0; i < 4; i++) pal_m[i] = '0;
  endtask

  // One pixel clock of stimulus; the expected output is pushed for two cycles later
  task automatic pix(input int col, input int row, input bit act, input bit hs_a,
                     input bit vs_a, input logic [23:0] rgb);
    exp_t e;
    logic [23:0] o;
    @(posedge clk); #1;
    spr_we = 0; pal_we = 0;
    {r_i, g_i, b_i} = rgb;
    hsync_i = hs_a ? SP : ~SP;
    vsync_i = vs_a ? SP : ~SP;
    blank_i = ~act;
    if (vs_a && !vs_prev_m) begin
      en_m = cfg_en; px_m = int'(cfg_x); py_m = int'(cfg_y);
    end
    vs_prev_m = vs_a;
    o = rgb;
    if (act && en_m && col >= px_m && col - px_m < SW && row >= py_m && row - py_m < SH) begin
      int id;
      id = bm[(row - py_m) * SW + (col - px_m)];
      if (id != 0) o = pal_m[id];
    end
    e.cyc = cyc + 2; e.col = col; e.row = row;
    e.v = {o, hsync_i, vsync_i, blank_i};
    q.push_back(e);
  endtask

  task automatic line(input int row, input int aw, input bit act, input bit vs);
    logic [23:0] c;
    for (int i = 0; i < aw; i++) begin
      c = $urandom;
      if (ramp) c[23:16] = 8'(i);
      pix(i, row, act, 1'b0, vs, c);
    end
    for (int h = 0; h < HB; h++)
      pix(0, row, 1'b0, (h >= 3 && h < 7), vs, 24'($urandom));
  endtask

  task automatic frame(input int aw, input int ah);
    for (int l = 0; l < 2; l++) line(0, aw, 1'b0, 1'b1);
    for (int l = 0; l < 2; l++) line(0, aw, 1'b0, 1'b0);
    for (int r = 0; r < ah; r++) begin
      if (r == chg_row) cfg_x = PW'(chg_x);
      line(r, aw, 1'b1, 1'b0);
    end
  endtask

  task automatic wr(input bit sw, input int a, input int d, input bit pw, input int sel,
                    input logic [23:0] pd);
    @(posedge clk); #1;
    spr_we = sw; spr_addr = AW'(a); spr_wdata = 2'(d);
    pal_we = pw; pal_sel = 2'(sel); pal_data = pd;
    if (sw) bm[a] = d;
    if (pw && sel != 0) pal_m[sel] = pd;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; r_i = 8'h11; g_i = 8'h22; b_i = 8'h33;
    hsync_i = ~SP; vsync_i = ~SP; blank_i = 1;
    cfg_en = 0; cfg_x = '0; cfg_y = '0;
    spr_we = 0; spr_addr = '0; spr_wdata = '0;
    pal_we = 0; pal_sel = '0; pal_data = '0;
    ramp = 0; chg_row = -1; chg_x = 0;
    for (int i = 0; i < SW*SH; i++) bm[i] = 0;
    model_reset();

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        while (!rst && q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk($sformatf("pix(%0d,%0d)", e.col, e.row),
              {5'd0, r_o, g_o, b_o, hsync_o, vsync_o, blank_o}, {5'd0, e.v});
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {8'd0, r_o, g_o, b_o}, 32'd0);
    chk("rst_blank", {31'd0, blank_o}, 32'd1);
    chk("rst_hs", {31'd0, hsync_o}, {31'd0, ~SP});
    chk("rst_vs", {31'd0, vsync_o}, {31'd0, ~SP});
    @(posedge clk); #2; rst = 0;

    // Passthrough with a red ramp and sprite disabled
    ramp = 1; cfg_en = 0;
    frame(128, 12);
    ramp = 0;

    // Single sprite pixel at (105,53); also a pal_sel=0 write that must be ignored
    for (int a = 0; a < SW*SH; a++) wr(1, a, 0, 0, 0, 24'h0);
    wr(1, 3*SW + 5, 1, 1, 1, 24'hFF0000);
    wr(0, 0, 0, 1, 0, 24'h123456);
    cfg_en = 1; cfg_x = 11'd100; cfg_y = 11'd50;
    frame(128, 58);

    // Index pattern 0,1,2,3 with distinct palettes at random positions
    for (int a = 0; a < SW*SH; a++)
      wr(1, a, a % 4, (a < 3), a + 1, (a == 0) ? 24'h00FF00 : (a == 1) ? 24'h0000FF : 24'hA5C3E7);
    for (int k = 0; k < 2; k++) begin
      cfg_x = PW'($urandom_range(0, 50)); cfg_y = PW'($urandom_range(0, 30));
      frame(64, 44);
    end

    // Right-edge clipping on a 640-wide line
    cfg_x = 11'd630; cfg_y = 11'd2;
    frame(640, 6);

    // Shadowing: mid-frame position change only shows in the next frame
    cfg_x = 11'd10; cfg_y = 11'd4; chg_row = 20; chg_x = 30;
    frame(64, 40);
    chg_row = -1;
    frame(64, 40);

    // Mid-line asynchronous reset with the sprite on screen
    for (int i = 0; i < 20; i++) pix(i, 5, 1'b1, 1'b0, 1'b0, 24'($urandom) | 24'h010101);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("midrst_rgb", {8'd0, r_o, g_o, b_o}, 32'd0);
    chk("midrst_blank", {31'd0, blank_o}, 32'd1);
    chk("midrst_hs", {31'd0, hsync_o}, {31'd0, ~SP});
    chk("midrst_vs", {31'd0, vsync_o}, {31'd0, ~SP});
    q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2; rst = 0;
    // Sprite stays off until a vsync; palette now reads back as zero
    for (int r = 0; r < 3; r++) line(r + 8, 64, 1'b1, 1'b0);
    frame(64, 40);

    repeat (5) @(posedge clk);
    #1;
    chk("drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dvga_sprite_overlay.md
Name: dvga_sprite_overlay

Overview:
- Parametrised post-stage of the dvga pixel pipeline.
- Overlays one hardware sprite (for example a cursor) on the incoming RGB stream before the DAC/output register.
- Sprite is a 2-bit-per-pixel bitmap with a 3-entry colour palette; index 0 is transparent.
- Delays RGB, hsync, vsync and blank by an identical fixed latency so all outputs stay aligned.

Parameters:
- SPR_W, 32: sprite width in pixels; power of 2, range 8..64.
- SPR_H, 32: sprite height in lines; power of 2, range 8..64.
- CW, 8: bits per colour channel.
- PW, 11: width of the position registers and the x/y pixel counters.
- SYNC_POL, 0: active level of hsync_i/vsync_i (0 = active-low).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-high.
- r_i/g_i/b_i  in  CW each  input colour.
- hsync_i, vsync_i, blank_i  in  1 each  input timing; blank_i=1 outside the active area.
- r_o/g_o/b_o  out  CW each  overlaid colour.
- hsync_o, vsync_o, blank_o  out  1 each  delayed timing.
- cfg_en  in  1  sprite enable (shadowed).
- cfg_x, cfg_y  in  PW each  top-left sprite position in active pixels/lines (shadowed).
- spr_we  in  1  bitmap write strobe.
- spr_addr  in  AW  bitmap address, AW = log2(SPR_W*SPR_H); address = row*SPR_W + col.
- spr_wdata  in  2  bitmap pixel index.
- pal_we  in  1  palette write strobe.
- pal_sel  in  2  palette entry 1..3; a write with pal_sel=0 is ignored.
- pal_data  in  3*CW  colour {r,g,b}.

Behaviour:
- Reset (asynchronous):
  - r_o/g_o/b_o = 0, blank_o = 1, hsync_o = vsync_o = ~SYNC_POL.
  - Pipeline registers cleared the same way; x/y counters = 0.
  - Active position and enable = 0; palette entries = 0.
  - Bitmap RAM contents are not reset.
- Latency: exactly 2 clk for every output, whether or not the sprite is enabled.
- Pixel counters:
  - x increments on each cycle with blank_i=0; cleared on any cycle with blank_i=1.
  - y increments on the cycle blank_i rises after at least one active pixel on that line.
  - y is cleared while vsync_i == SYNC_POL.
  - Both counters wrap modulo 2^PW; no saturation.
- Shadowing: on the first cycle vsync_i becomes active, cfg_en/cfg_x/cfg_y load into the active registers. Mid-frame cfg changes have no effect until the next vsync.
- Stage 0 (hit test and address):
  - dx = x - pos_x, dy = y - pos_y, computed in PW+1 bits.
  - hit = en & ~blank_i & (x >= pos_x) & (dx < SPR_W) & (y >= pos_y) & (dy < SPR_H). Comparisons are unsigned.
  - A sprite partly beyond the right or bottom edge is clipped naturally.
  - Synchronous bitmap read at address dy*SPR_W + dx; hit is registered alongside the read.
- Stage 1 (colour select):
  - If hit_d and idx != 0, output palette[idx]; otherwise output the input colour delayed 2 cycles.
  - During blank, the input colour is passed through delayed.
- Bitmap RAM:
  - Single write port plus one read port.
  - A write and a read to the same address in the same cycle return the old data.
  - Writes are allowed at any time; a write takes effect for pixels read on the next cycle onward.
- Palette writes take effect on the next clk. A write in the same cycle as a stage-1 lookup uses the old value.
- Simultaneous spr_we and pal_we are both performed.
- Reset asserted mid-frame:
  - Outputs go to reset values immediately.
  - After release, the counters resynchronise on the next blank/vsync.
  - The sprite stays disabled until a vsync loads cfg_en=1.

Test Plan:
- Reset: assert rst mid-line -> outputs r/g/b=0, blank_o=1, hsync_o=vsync_o=1 without waiting for a clk edge.
- Passthrough: cfg_en=0, ramp r_i=0..255 on a 640x480 frame -> r_o equals r_i delayed exactly 2 clk; sync and blank also delayed 2.
- Hit:
  - Setup: bitmap all 0 except (row 3, col 5)=1; palette1=FF0000; cfg_x=100, cfg_y=50, en=1; then one vsync.
  - Expected: only pixel (105,53) outputs FF0000; all others pass through.
- Transparency and indices: fill the bitmap with the pattern 0,1,2,3 and palettes 1..3 distinct -> index-0 pixels show input colour, others show the matching palette colour.
- Clipping: cfg_x=630 on a 640-wide line -> sprite columns 0..9 drawn at x=630..639; no wrap into x=0..21 of the next line.
- Shadowing: change cfg_x from 100 to 200 at line 240 -> the current frame stays at 100; the next frame is at 200.
